// File: rtl/ctrl_unit_if.sv
// Memory and ALU bus between the accumulator-CPU sequencer and its
// byte memory / alu block. The sequencer side uses the master modport.
interface ctrl_unit_if;
    logic [7:0] mem_addr_o;
    logic [7:0] mem_rdata_i;
    logic [7:0] mem_wdata_o;
    logic       mem_we_o;
    logic [2:0] alu_func_o;
    logic [7:0] alu_a_imm_o;
    logic [7:0] alu_a_mem_o;
    logic [7:0] alu_b_o;
    logic [7:0] alu_result_i;
    logic       alu_fz_i;
    logic       alu_fc_i;

    modport master (
        output mem_addr_o, mem_wdata_o, mem_we_o,
        output alu_func_o, alu_a_imm_o, alu_a_mem_o, alu_b_o,
        input  mem_rdata_i, alu_result_i, alu_fz_i, alu_fc_i
    );

    modport slave (
        input  mem_addr_o, mem_wdata_o, mem_we_o,
        input  alu_func_o, alu_a_imm_o, alu_a_mem_o, alu_b_o,
        output mem_rdata_i, alu_result_i, alu_fz_i, alu_fc_i
    );
endinterface

// File: rtl/ctrl_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Owns PC, ACC and the Z/C flags; fetches two-byte instructions from a
// synchronous-read byte memory and drives the external alu block.
module ctrl_unit (
    input  logic              clk_i,
    input  logic              rst_ni,
    ctrl_unit_if.master       bus,
    output logic [7:0]        acc_o,
    output logic [7:0]        pc_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    output logic              halted_o
);

    localparam logic [2:0] ST_F0   = 3'd0;
    localparam logic [2:0] ST_F1   = 3'd1;
    localparam logic [2:0] ST_F2   = 3'd2;
    localparam logic [2:0] ST_M0   = 3'd3;
    localparam logic [2:0] ST_M1   = 3'd4;
    localparam logic [2:0] ST_EX   = 3'd5;
    localparam logic [2:0] ST_HALT = 3'd6;

    localparam logic [3:0] CL_ALU = 4'h1;
    localparam logic [3:0] CL_LDA = 4'h2;
    localparam logic [3:0] CL_STA = 4'h3;
    localparam logic [3:0] CL_JMP = 4'h4;
    localparam logic [3:0] CL_JZ  = 4'h5;
    localparam logic [3:0] CL_JC  = 4'h6;
    localparam logic [3:0] CL_HLT = 4'h7;

    logic [2:0] r_state;
    logic [2:0] w_nextState;
    logic [7:0] r_pc;
    logic [7:0] r_acc;
    // Opcode bit 3 selects nothing, so only {op[7:4], op[2:0]} is kept.
    logic [6:0] r_opc;
    logic [7:0] r_arg;
    logic [7:0] r_mdr;
    logic       r_z;
    logic       r_c;

    logic [3:0] w_class;
    logic [2:0] w_func;
    logic       w_needsOperand;
    logic       w_isStore;

    assign w_class        = r_opc[6:3];
    assign w_func         = r_opc[2:0];
    assign w_needsOperand = ((w_class == CL_ALU) && (w_func != 3'b000)) || (w_class == CL_LDA);
    assign w_isStore      = (r_state == ST_EX) && (w_class == CL_STA);

    // Next-state selection; HALT only leaves through reset.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_F0:   w_nextState = ST_F1;
            ST_F1:   w_nextState = ST_F2;
            ST_F2:   w_nextState = w_needsOperand ? ST_M0 : ST_EX;
            ST_M0:   w_nextState = ST_M1;
            ST_M1:   w_nextState = ST_EX;
            ST_EX:   w_nextState = (w_class == CL_HLT) ? ST_HALT : ST_F0;
            ST_HALT: w_nextState = ST_HALT;
            default: w_nextState = ST_F0;
        endcase
    end

    // State register plus all architectural and fetch registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_F0;
            r_pc    <= 8'h00;
            r_acc   <= 8'h00;
            r_opc   <= 7'h00;
            r_arg   <= 8'h00;
            r_mdr   <= 8'h00;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                ST_F1: r_opc <= {bus.mem_rdata_i[7:4], bus.mem_rdata_i[2:0]};
                ST_F2: begin
                    r_arg <= bus.mem_rdata_i;
                    r_pc  <= r_pc + 8'd2;
                end
                ST_M1: r_mdr <= bus.mem_rdata_i;
                ST_EX: begin
                    case (w_class)
                        CL_ALU: begin
                            r_acc <= bus.alu_result_i;
                            r_z   <= bus.alu_fz_i;
                            r_c   <= bus.alu_fc_i;
                        end
                        CL_LDA: begin
                            r_acc <= r_mdr;
                            r_z   <= (r_mdr == 8'h00);
                        end
                        CL_JMP: r_pc <= r_arg;
                        CL_JZ:  if (r_z) r_pc <= r_arg;
                        CL_JC:  if (r_c) r_pc <= r_arg;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Memory address: argument fetch, operand read and store override PC.
    always_comb begin
        bus.mem_addr_o = r_pc;
        if (r_state == ST_F1) begin
            bus.mem_addr_o = r_pc + 8'd1;
        end else if ((r_state == ST_M0) || w_isStore) begin
            bus.mem_addr_o = r_arg;
        end
    end

    assign bus.mem_we_o    = w_isStore;
    assign bus.mem_wdata_o = r_acc;
    assign bus.alu_func_o  = w_func;
    assign bus.alu_a_imm_o = r_arg;
    assign bus.alu_a_mem_o = r_mdr;
    assign bus.alu_b_o     = r_acc;

    assign acc_o    = r_acc;
    assign pc_o     = r_pc;
    assign flag_z_o = r_z;
    assign flag_c_o = r_c;
    assign halted_o = (r_state == ST_HALT);

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit with a synchronous-read byte memory and a
// small alu model (000 ADD imm, 001 ADD, 010 SUB, 011 AND, 100 OR,
// 101 XOR, 110 pass mem, 111 NOT acc).
module tb_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] acc, pc;
    logic       flagZ, flagC, halted;
    logic [7:0] mem [256];
    int         total = 0;
    int         bad = 0;
    int         weCount = 0;
    logic [7:0] lastWeAddr = 8'h00;
    logic [7:0] lastWeData = 8'h00;

    ctrl_unit_if bus ();

    ctrl_unit dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus      (bus),
        .acc_o    (acc),
        .pc_o     (pc),
        .flag_z_o (flagZ),
        .flag_c_o (flagC),
        .halted_o (halted)
    );

    initial forever #5 clk = ~clk;

    // Byte memory: registered read, write on the strobed edge.
    always @(posedge clk) begin
        if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
        bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end

    // Record every write strobe seen on a clock edge.
    always @(posedge clk) begin
        if (bus.mem_we_o) begin
            weCount = weCount + 1;
            lastWeAddr = bus.mem_addr_o;
            lastWeData = bus.mem_wdata_o;
        end
    end

    // Reference alu.
    always_comb begin
        logic [8:0] sum;
        sum = 9'h000;
        case (bus.alu_func_o)
            3'b000: sum = {1'b0, bus.alu_b_o} + {1'b0, bus.alu_a_imm_o};
            3'b001: sum = {1'b0, bus.alu_b_o} + {1'b0, bus.alu_a_mem_o};
            3'b010: sum = {1'b0, bus.alu_b_o} - {1'b0, bus.alu_a_mem_o};
            3'b011: sum = {1'b0, bus.alu_b_o & bus.alu_a_mem_o};
            3'b100: sum = {1'b0, bus.alu_b_o | bus.alu_a_mem_o};
            3'b101: sum = {1'b0, bus.alu_b_o ^ bus.alu_a_mem_o};
            3'b110: sum = {1'b0, bus.alu_a_mem_o};
            default: sum = {1'b0, ~bus.alu_b_o};
        endcase
        bus.alu_result_i = sum[7:0];
        bus.alu_fc_i     = sum[8];
        bus.alu_fz_i     = (sum[7:0] == 8'h00);
    end

    task automatic holdReset();
        rst_n = 1'b0;
        weCount = 0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    endtask

    task automatic release_();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        holdReset();
        @(negedge clk);
        total++; if (acc !== 8'h00) begin bad++; $display("[TB] FAIL reset_acc got=%h exp=00", acc); end
        total++; if (pc !== 8'h00) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=00", pc); end
        total++; if (bus.mem_addr_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=00", bus.mem_addr_o); end
        total++; if ({bus.mem_we_o, halted, flagZ, flagC} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_bits got=%b exp=0000", {bus.mem_we_o, halted, flagZ, flagC}); end
        total++; if (bus.alu_func_o !== 3'b000) begin bad++; $display("[TB] FAIL reset_func got=%b exp=000", bus.alu_func_o); end
    endtask

    task automatic test_adi();
        holdReset();
        mem[8'h00] <= 8'h10; mem[8'h01] <= 8'h05;
        release_();
        waitCycles(3);
        total++; if (bus.alu_func_o !== 3'b000) begin bad++; $display("[TB] FAIL adi_func got=%b exp=000", bus.alu_func_o); end
        total++; if (bus.alu_a_imm_o !== 8'h05) begin bad++; $display("[TB] FAIL adi_imm got=%h exp=05", bus.alu_a_imm_o); end
        total++; if (acc !== 8'h00) begin bad++; $display("[TB] FAIL adi_acc_early got=%h exp=00", acc); end
        waitCycles(1);
        total++; if (acc !== 8'h05) begin bad++; $display("[TB] FAIL adi_acc got=%h exp=05", acc); end
        total++; if (flagZ !== 1'b0) begin bad++; $display("[TB] FAIL adi_z got=%b exp=0", flagZ); end
        total++; if (pc !== 8'h02) begin bad++; $display("[TB] FAIL adi_pc got=%h exp=02", pc); end
    endtask

    task automatic test_lda_sta();
        holdReset();
        mem[8'h00] <= 8'h20; mem[8'h01] <= 8'h80;
        mem[8'h02] <= 8'h30; mem[8'h03] <= 8'h81;
        mem[8'h04] <= 8'h70; mem[8'h80] <= 8'h3C;
        release_();
        waitCycles(6);
        total++; if (acc !== 8'h3C) begin bad++; $display("[TB] FAIL lda_acc got=%h exp=3c", acc); end
        waitCycles(3);
        total++; if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 8'h81, 8'h3C}) begin bad++; $display("[TB] FAIL sta_strobe got=%h exp=1813c", {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}); end
        waitCycles(1);
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("[TB] FAIL sta_we_drop got=%b exp=0", bus.mem_we_o); end
        waitCycles(3);
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL hlt_early got=%b exp=0", halted); end
        waitCycles(1);
        total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL hlt_rise got=%b exp=1", halted); end
        waitCycles(5);
        total++; if (pc !== 8'h06) begin bad++; $display("[TB] FAIL hlt_pc got=%h exp=06", pc); end
        total++; if (weCount !== 1) begin bad++; $display("[TB] FAIL sta_count got=%0d exp=1", weCount); end
        total++; if ({lastWeAddr, lastWeData, mem[8'h81]} !== {8'h81, 8'h3C, 8'h3C}) begin bad++; $display("[TB] FAIL sta_data got=%h exp=813c3c", {lastWeAddr, lastWeData, mem[8'h81]}); end
        total++; if ({halted, bus.mem_we_o} !== 2'b10) begin bad++; $display("[TB] FAIL hlt_hold got=%b exp=10", {halted, bus.mem_we_o}); end
    endtask

    task automatic test_alu_mem();
        holdReset();
        mem[8'h00] <= 8'h10; mem[8'h01] <= 8'h0F;
        mem[8'h02] <= 8'h13; mem[8'h03] <= 8'hA0;
        mem[8'h04] <= 8'h70; mem[8'hA0] <= 8'hF0;
        release_();
        waitCycles(7);
        total++; if (bus.mem_addr_o !== 8'hA0) begin bad++; $display("[TB] FAIL and_m0_addr got=%h exp=a0", bus.mem_addr_o); end
        waitCycles(2);
        total++; if ({bus.alu_func_o, bus.alu_a_mem_o, bus.alu_b_o} !== {3'b011, 8'hF0, 8'h0F}) begin bad++; $display("[TB] FAIL and_ex_ops got=%h exp=%h", {bus.alu_func_o, bus.alu_a_mem_o, bus.alu_b_o}, {3'b011, 8'hF0, 8'h0F}); end
        total++; if (acc !== 8'h0F) begin bad++; $display("[TB] FAIL and_acc_early got=%h exp=0f", acc); end
        waitCycles(1);
        total++; if ({acc, flagZ, flagC} !== {8'h00, 1'b1, 1'b0}) begin bad++; $display("[TB] FAIL and_wb got=%h exp=%h", {acc, flagZ, flagC}, {8'h00, 2'b10}); end
        total++; if (pc !== 8'h04) begin bad++; $display("[TB] FAIL and_pc got=%h exp=04", pc); end
    endtask

    task automatic test_branches();
        // JZ taken after loading zero
        holdReset();
        mem[8'h00] <= 8'h20; mem[8'h01] <= 8'h90;
        mem[8'h02] <= 8'h50; mem[8'h03] <= 8'h40;
        mem[8'h90] <= 8'h00; mem[8'h40] <= 8'h70;
        release_();
        waitCycles(6);
        total++; if (flagZ !== 1'b1) begin bad++; $display("[TB] FAIL jz_setz got=%b exp=1", flagZ); end
        waitCycles(4);
        total++; if (pc !== 8'h40) begin bad++; $display("[TB] FAIL jz_taken got=%h exp=40", pc); end
        // JZ and JC fall through with Z=0, C=0
        holdReset();
        mem[8'h00] <= 8'h20; mem[8'h01] <= 8'h90;
        mem[8'h02] <= 8'h50; mem[8'h03] <= 8'h40;
        mem[8'h04] <= 8'h60; mem[8'h05] <= 8'h40;
        mem[8'h90] <= 8'h07;
        release_();
        waitCycles(10);
        total++; if ({pc, acc, flagZ} !== {8'h04, 8'h07, 1'b0}) begin bad++; $display("[TB] FAIL jz_not_taken got=%h exp=%h", {pc, acc, flagZ}, {8'h04, 8'h07, 1'b0}); end
        waitCycles(4);
        total++; if (pc !== 8'h06) begin bad++; $display("[TB] FAIL jc_not_taken got=%h exp=06", pc); end
        // JC taken after an ADI carry-out
        holdReset();
        mem[8'h00] <= 8'h10; mem[8'h01] <= 8'hFF;
        mem[8'h02] <= 8'h10; mem[8'h03] <= 8'h01;
        mem[8'h04] <= 8'h60; mem[8'h05] <= 8'h80;
        release_();
        waitCycles(8);
        total++; if ({acc, flagZ, flagC} !== {8'h00, 1'b1, 1'b1}) begin bad++; $display("[TB] FAIL adi_carry got=%h exp=%h", {acc, flagZ, flagC}, {8'h00, 2'b11}); end
        waitCycles(4);
        total++; if (pc !== 8'h80) begin bad++; $display("[TB] FAIL jc_taken got=%h exp=80", pc); end
    endtask

    task automatic test_wrap();
        // Opcode at 0xFF takes its argument from 0x00
        holdReset();
        mem[8'h00] <= 8'h01; mem[8'h01] <= 8'h00;
        mem[8'h02] <= 8'h40; mem[8'h03] <= 8'hFF;
        mem[8'hFF] <= 8'h10;
        release_();
        waitCycles(8);
        total++; if ({pc, bus.mem_addr_o} !== {8'hFF, 8'hFF}) begin bad++; $display("[TB] FAIL wrap_jmp got=%h exp=ffff", {pc, bus.mem_addr_o}); end
        waitCycles(1);
        total++; if (bus.mem_addr_o !== 8'h00) begin bad++; $display("[TB] FAIL wrap_f1_addr got=%h exp=00", bus.mem_addr_o); end
        waitCycles(3);
        total++; if ({acc, pc} !== {8'h01, 8'h01}) begin bad++; $display("[TB] FAIL wrap_ff got=%h exp=0101", {acc, pc}); end
        // Opcode at 0xFE wraps PC to 0x00
        holdReset();
        mem[8'h02] <= 8'h40; mem[8'h03] <= 8'hFE;
        release_();
        waitCycles(12);
        total++; if (pc !== 8'h00) begin bad++; $display("[TB] FAIL wrap_fe got=%h exp=00", pc); end
    endtask

    task automatic test_reset_mid_op();
        holdReset();
        mem[8'h00] <= 8'h10; mem[8'h01] <= 8'h22;
        mem[8'h02] <= 8'h20; mem[8'h03] <= 8'h80;
        mem[8'h04] <= 8'h30; mem[8'h05] <= 8'h81;
        mem[8'h80] <= 8'h55; mem[8'h81] <= 8'hEE;
        release_();
        // Abort in M1 of the LDA
        waitCycles(8);
        rst_n = 1'b0;
        #1;
        total++; if ({acc, pc, bus.mem_addr_o} !== 24'h000000) begin bad++; $display("[TB] FAIL m1_reset_regs got=%h exp=000000", {acc, pc, bus.mem_addr_o}); end
        total++; if ({halted, flagZ, bus.alu_a_imm_o} !== 10'h000) begin bad++; $display("[TB] FAIL m1_reset_misc got=%h exp=000", {halted, flagZ, bus.alu_a_imm_o}); end
        @(negedge clk);
        total++; if (acc !== 8'h00) begin bad++; $display("[TB] FAIL m1_no_wb got=%h exp=00", acc); end
        rst_n = 1'b1;
        total++; if (bus.mem_addr_o !== 8'h00) begin bad++; $display("[TB] FAIL restart_f0 got=%h exp=00", bus.mem_addr_o); end
        waitCycles(1);
        total++; if (bus.mem_addr_o !== 8'h01) begin bad++; $display("[TB] FAIL restart_f1 got=%h exp=01", bus.mem_addr_o); end
        waitCycles(3);
        total++; if ({acc, pc} !== {8'h22, 8'h02}) begin bad++; $display("[TB] FAIL restart_adi got=%h exp=2202", {acc, pc}); end
        // Abort in EX of the STA: the strobe must vanish at once
        waitCycles(9);
        total++; if (bus.mem_we_o !== 1'b1) begin bad++; $display("[TB] FAIL sta_ex_we got=%b exp=1", bus.mem_we_o); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("[TB] FAIL async_we_drop got=%b exp=0", bus.mem_we_o); end
        @(negedge clk);
        total++; if ({mem[8'h81], weCount[7:0]} !== {8'hEE, 8'h00}) begin bad++; $display("[TB] FAIL aborted_store got=%h exp=ee00", {mem[8'h81], weCount[7:0]}); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_adi();
        test_lda_sta();
        test_alu_mem();
        test_branches();
        test_wrap();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
